// File: rtl/alu_top.sv
// alu_top: board-level ALU wrapper for the TP1 FPGA design.
// Three input registers (operand A, operand B, opcode) share one data bus
// and load under individual enables; a combinational ALU drives the LEDs.
//
// Ports:
//   i_clk        system clock, all state on rising edge
//   i_reset      synchronous active-high reset (clears A, B, opcode)
//   i_data       shared input bus (operand value or opcode in its MSBs)
//   i_enable_1   load operand A from i_data
//   i_enable_2   load operand B from i_data
//   i_enable_3   load opcode from i_data[NB_DATA-1 -: NB_OP]
//   o_led_data   ALU result
//   o_led_carry  carry (ADD) / borrow (SUB), 0 otherwise
//   o_led_zero   1 when o_led_data == 0
module alu_top #(
    parameter int NB_DATA = 8,
    parameter int NB_LEDS = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_data,
    input  logic               i_enable_1,
    input  logic               i_enable_2,
    input  logic               i_enable_3,
    output logic [NB_LEDS-1:0] o_led_data,
    output logic               o_led_carry,
    output logic               o_led_zero
);

    typedef enum logic [NB_OP-1:0] {
        OP_ADD = 6'b100000,
        OP_SUB = 6'b100010,
        OP_AND = 6'b100100,
        OP_OR  = 6'b100101,
        OP_XOR = 6'b100110,
        OP_NOR = 6'b100111,
        OP_SRA = 6'b000011,
        OP_SRL = 6'b000010
    } alu_op_e;

    logic [NB_DATA-1:0] a_q, a_d;
    logic [NB_DATA-1:0] b_q, b_d;
    logic [NB_OP-1:0]   op_q, op_d;

    logic [NB_DATA:0]   sum;
    logic [NB_DATA:0]   diff;
    logic [NB_DATA-1:0] result;
    logic               carry;

    // Input register next-state: each enable loads independently.
    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        op_d = op_q;
        if (i_enable_1) a_d  = i_data;
        if (i_enable_2) b_d  = i_data;
        if (i_enable_3) op_d = i_data[NB_DATA-1 -: NB_OP];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else begin
            a_q  <= a_d;
            b_q  <= b_d;
            op_q <= op_d;
        end
    end

    // Combinational ALU.
    always_comb begin
        sum    = {1'b0, a_q} + {1'b0, b_q};
        diff   = {1'b0, a_q} - {1'b0, b_q};
        result = '0;
        carry  = 1'b0;
        case (op_q)
            OP_ADD: begin
                result = sum[NB_DATA-1:0];
                carry  = sum[NB_DATA];
            end
            OP_SUB: begin
                result = diff[NB_DATA-1:0];
                // Borrow out of the widened subtraction equals (A < B).
                carry  = diff[NB_DATA];
            end
            OP_AND: result = a_q & b_q;
            OP_OR:  result = a_q | b_q;
            OP_XOR: result = a_q ^ b_q;
            OP_NOR: result = ~(a_q | b_q);
            // Shift amounts >= NB_DATA saturate to all sign bits / zero.
            OP_SRA: result = $signed(a_q) >>> b_q;
            OP_SRL: result = a_q >> b_q;
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

    assign o_led_data  = result;
    assign o_led_carry = carry;
    assign o_led_zero  = (result == '0);

endmodule

// File: tb/tb_alu_top.sv
// tb_alu_top: self-checking bench for alu_top. Directed vectors use
// hand-derived constants; random traffic is checked against an integer
// model of the register file and opcode table.
module tb_alu_top;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       en1, en2, en3;
    logic [7:0] led_data;
    logic       led_carry, led_zero;

    int checks   = 0;
    int failures = 0;

    // Model state
    int m_a, m_b, m_op;

    alu_top #(.NB_DATA(8), .NB_LEDS(8), .NB_OP(6)) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_data     (data),
        .i_enable_1 (en1),
        .i_enable_2 (en2),
        .i_enable_3 (en3),
        .o_led_data (led_data),
        .o_led_carry(led_carry),
        .o_led_zero (led_zero)
    );

    always #5 clk = ~clk;

    // Reference ALU from the opcode table, using plain integer arithmetic.
    function automatic void model(input int a, input int b, input int op,
                                  output int r, output int c);
        int sa, sh;
        r = 0;
        c = 0;
        case (op)
            32: begin r = (a + b) % 256; c = (a + b) / 256; end
            34: begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            36: r = a & b;
            37: r = a | b;
            38: r = a ^ b;
            39: r = 255 - (a | b);
            3: begin
                sa = (a >= 128) ? a - 256 : a;
                sh = (b > 8) ? 8 : b;
                r  = (sa >>> sh) & 255;
            end
            2: r = (b >= 8) ? 0 : (a >> b);
            default: begin r = 0; c = 0; end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock with the given controls; the model tracks the registers.
    task automatic drive(input logic r, input logic e1, input logic e2,
                         input logic e3, input logic [7:0] d);
        rst = r; en1 = e1; en2 = e2; en3 = e3; data = d;
        tick();
        if (r) begin
            m_a = 0; m_b = 0; m_op = 0;
        end else begin
            if (e1) m_a  = int'(d);
            if (e2) m_b  = int'(d);
            if (e3) m_op = int'(d) >> 2;
        end
        rst = 1'b0; en1 = 1'b0; en2 = 1'b0; en3 = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);
        checks++;
        if (led_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data got=%h exp=00", led_data);
        end
        checks++;
        if (led_carry !== 1'b0) begin
            failures++;
            $display("FAIL reset_carry got=%b exp=0", led_carry);
        end
        checks++;
        if (led_zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_zero got=%b exp=1", led_zero);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op_bus;
        logic [7:0] r;
        logic       c;
    } vec_t;

    task automatic test_directed();
        vec_t v[18];
        v[0]  = '{8'd15,  8'd10,  8'h80, 8'd25,  1'b0};
        v[1]  = '{8'd200, 8'd100, 8'h80, 8'd44,  1'b1};
        v[2]  = '{8'd128, 8'd128, 8'h80, 8'h00,  1'b1};
        v[3]  = '{8'hAA,  8'h55,  8'h90, 8'h00,  1'b0};
        v[4]  = '{8'hFF,  8'h0F,  8'h90, 8'h0F,  1'b0};
        v[5]  = '{8'hFF,  8'hFF,  8'h90, 8'hFF,  1'b0};
        v[6]  = '{8'd5,   8'd7,   8'h88, 8'hFE,  1'b1};
        v[7]  = '{8'h80,  8'd2,   8'h0C, 8'hE0,  1'b0};
        v[8]  = '{8'h80,  8'd2,   8'h08, 8'h20,  1'b0};
        v[9]  = '{8'h00,  8'h00,  8'h9C, 8'hFF,  1'b0};
        v[10] = '{8'h80,  8'd9,   8'h0C, 8'hFF,  1'b0};
        v[11] = '{8'h7F,  8'd9,   8'h0C, 8'h00,  1'b0};
        v[12] = '{8'h80,  8'd9,   8'h08, 8'h00,  1'b0};
        v[13] = '{8'h12,  8'h34,  8'h3F, 8'h00,  1'b0};
        v[14] = '{8'h12,  8'h34,  8'hFF, 8'h00,  1'b0};
        v[15] = '{8'hAA,  8'h0F,  8'h98, 8'hA5,  1'b0};
        v[16] = '{8'hA0,  8'h05,  8'h94, 8'hA5,  1'b0};
        v[17] = '{8'd7,   8'd7,   8'h8B, 8'h00,  1'b0};  // SUB, op bits[1:0] ignored
        for (int i = 0; i < 18; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, v[i].a);
            drive(1'b0, 1'b0, 1'b1, 1'b0, v[i].b);
            drive(1'b0, 1'b0, 1'b0, 1'b1, v[i].op_bus);
            checks++;
            if (led_data !== v[i].r) begin
                failures++;
                $display("FAIL dir%0d_data got=%h exp=%h", i, led_data, v[i].r);
            end
            checks++;
            if (led_carry !== v[i].c) begin
                failures++;
                $display("FAIL dir%0d_carry got=%b exp=%b", i, led_carry, v[i].c);
            end
            checks++;
            if (led_zero !== (v[i].r == 8'h00)) begin
                failures++;
                $display("FAIL dir%0d_zero got=%b exp=%b", i, led_zero, (v[i].r == 8'h00));
            end
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd15);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd10);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h80);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom));
            checks++;
            if (led_data !== 8'd25 || led_carry !== 1'b0 || led_zero !== 1'b0) begin
                failures++;
                $display("FAIL hold%0d got=%h/%b/%b exp=19/0/0", i, led_data, led_carry, led_zero);
            end
        end
    endtask

    task automatic test_reset_midsequence();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd200);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'd100);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h80);
        checks++;
        if (led_data !== 8'h00 || led_carry !== 1'b0 || led_zero !== 1'b1) begin
            failures++;
            $display("FAIL midreset_clear got=%h/%b/%b exp=00/0/1", led_data, led_carry, led_zero);
        end
        // B was loaded before reset; it must not survive.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h80);
        checks++;
        if (led_data !== 8'd3 || led_carry !== 1'b0 || led_zero !== 1'b0) begin
            failures++;
            $display("FAIL midreset_restart got=%h/%b/%b exp=03/0/0", led_data, led_carry, led_zero);
        end
    endtask

    task automatic test_simultaneous();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h80);  // A=B=0x80, op=ADD
        checks++;
        if (led_data !== 8'h00 || led_carry !== 1'b1 || led_zero !== 1'b1) begin
            failures++;
            $display("FAIL simul_add got=%h/%b/%b exp=00/1/1", led_data, led_carry, led_zero);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h05);  // A=B=5, op stays ADD
        checks++;
        if (led_data !== 8'h0A || led_carry !== 1'b0 || led_zero !== 1'b0) begin
            failures++;
            $display("FAIL simul_ab got=%h/%b/%b exp=0a/0/0", led_data, led_carry, led_zero);
        end
    endtask

    task automatic test_random();
        int ops[8] = '{32, 34, 36, 37, 38, 39, 3, 2};
        int er, ec;
        logic [7:0] d;
        logic [2:0] en;
        for (int i = 0; i < 400; i++) begin
            en = 3'($urandom);
            d  = 8'($urandom);
            if (en[2] && ($urandom_range(0, 9) < 7))
                d = 8'((ops[$urandom_range(0, 7)] << 2) | $urandom_range(0, 3));
            else if (en[1] && !en[0] && $urandom_range(0, 1) == 1)
                d = 8'($urandom_range(0, 10));
            drive(($urandom_range(0, 29) == 0), en[0], en[1], en[2], d);
            model(m_a, m_b, m_op, er, ec);
            checks++;
            if (led_data !== 8'(er)) begin
                failures++;
                $display("FAIL rnd%0d_data a=%0d b=%0d op=%0d got=%h exp=%h",
                         i, m_a, m_b, m_op, led_data, 8'(er));
            end
            checks++;
            if (led_carry !== 1'(ec)) begin
                failures++;
                $display("FAIL rnd%0d_carry a=%0d b=%0d op=%0d got=%b exp=%0d",
                         i, m_a, m_b, m_op, led_carry, ec);
            end
            checks++;
            if (led_zero !== (er == 0)) begin
                failures++;
                $display("FAIL rnd%0d_zero got=%b exp=%b", i, led_zero, (er == 0));
            end
        end
    endtask

    initial begin
        rst = 1'b1; en1 = 1'b0; en2 = 1'b0; en3 = 1'b0; data = 8'h00;
        m_a = 0; m_b = 0; m_op = 0;
        test_reset();
        test_directed();
        test_hold();
        test_reset_midsequence();
        test_simultaneous();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
